// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes and STATUS/CAUSE field positions.
package cp0_pkg;

  typedef enum logic [4:0] {
    CP0_REG_COUNT   = 5'd9,
    CP0_REG_COMPARE = 5'd11,
    CP0_REG_STATUS  = 5'd12,
    CP0_REG_CAUSE   = 5'd13,
    CP0_REG_EPC     = 5'd14
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_SYSCALL = 5'd8,
    EXC_BREAK   = 5'd9,
    EXC_TEQ     = 5'd13
  } exc_code_e;

  localparam int STATUS_IE  = 0;
  localparam int EXCCODE_LO = 2;
  localparam int EXCCODE_HI = 6;
  localparam int IP_LO      = 8;
  localparam int IP_HI      = 15;
  localparam int FRAME_W    = 5;

  // A synchronous exception reports its own code; an interrupt always reports EXC_INT.
  function automatic logic [4:0] entry_code(input logic sync_exc, input logic [4:0] code);
    logic [4:0] res;
    if (sync_exc) begin
      res = code;
    end else begin
      res = EXC_INT;
    end
    return res;
  endfunction

endpackage

// File: rtl/cp0_irq_sync.sv
// Two-stage falling-edge synchroniser for the external interrupt lines.
module cp0_irq_sync
  import cp0_pkg::*;
#(
  parameter int NUM_IRQ = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_out
);

  logic [NUM_IRQ-1:0] meta_q, meta_d;
  logic [NUM_IRQ-1:0] sync_q, sync_d;

  // Both stages hold while the block is disabled.
  always_comb begin
    meta_d = meta_q;
    sync_d = sync_q;
    if (ena) begin
      meta_d = irq_in;
      sync_d = meta_q;
    end else begin
      meta_d = meta_q;
      sync_d = sync_q;
    end
  end

  // Synchroniser stages.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign irq_out = sync_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: STATUS/CAUSE/EPC, nested STATUS frame stack, redirect vector.
// Optional COUNT/COMPARE timer on CAUSE.IP[7] when CP0_TIMER_EN is defined.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter int                 NUM_IRQ    = 6,
  parameter int                 NEST_DEPTH = 3,
  parameter logic [DATA_W-1:0]  EXC_VECTOR = 32'h0000_0004,
  parameter logic [DATA_W-1:0]  STATUS_RST = 32'h0000_0001
) (
  input  logic               cp0_clk,
  input  logic               cp0_rst,
  input  logic               cp0_ena,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic               eret,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic [4:0]         addr,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [DATA_W-1:0]  cp0_out,
  output logic [DATA_W-1:0]  epc_out,
  output logic               exc_taken,
  output logic [DATA_W-1:0]  exc_vector,
  output logic               nest_ovf
);

  localparam int LVL_W = $clog2(NEST_DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NEST_DEPTH);

  logic [DATA_W-1:0]  status_q, status_d;
  logic [DATA_W-1:0]  cause_q, cause_d;
  logic [DATA_W-1:0]  epc_q, epc_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               nest_ovf_q, nest_ovf_d;
  logic [NUM_IRQ-1:0] irq_sync_s;
  logic [7:0]         ip_vec_s;
  logic [DATA_W-1:0]  cause_rd_s;
  logic [DATA_W-1:0]  rd_data_s;
  logic               int_pend_s;
  logic               take_s;
`ifdef CP0_TIMER_EN
  logic [DATA_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0]  compare_q, compare_d;
  logic               timer_ip_q, timer_ip_d;
`endif

  cp0_irq_sync #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_sync (
    .clk     (cp0_clk),
    .rst     (cp0_rst),
    .ena     (cp0_ena),
    .irq_in  (irq),
    .irq_out (irq_sync_s)
  );

  // CAUSE.IP is never stored: it mirrors the synchronised lines (and the timer flag) every cycle.
  always_comb begin
    ip_vec_s = 8'h00;
    ip_vec_s[NUM_IRQ-1:0] = irq_sync_s;
`ifdef CP0_TIMER_EN
    ip_vec_s[7] = timer_ip_q;
`endif
    cause_rd_s = cause_q;
    cause_rd_s[IP_HI:IP_LO] = ip_vec_s;
    int_pend_s = status_q[STATUS_IE] & (|(ip_vec_s & status_q[IP_HI:IP_LO]));
    take_s     = cp0_ena & (exc_req | int_pend_s);
  end

  // mfc0 read mux.
  always_comb begin
    rd_data_s = '0;
    case (addr)
      CP0_REG_STATUS:  rd_data_s = status_q;
      CP0_REG_CAUSE:   rd_data_s = cause_rd_s;
      CP0_REG_EPC:     rd_data_s = epc_q;
`ifdef CP0_TIMER_EN
      CP0_REG_COUNT:   rd_data_s = count_q;
      CP0_REG_COMPARE: rd_data_s = compare_q;
`endif
      default:         rd_data_s = '0;
    endcase
  end

  // Next state: exception/interrupt entry outranks eret, which outranks mtc0.
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    level_d    = level_q;
    nest_ovf_d = nest_ovf_q;
`ifdef CP0_TIMER_EN
    count_d    = count_q;
    compare_d  = compare_q;
    timer_ip_d = timer_ip_q;
    if (cp0_ena) begin
      count_d = count_q + DATA_W'(1);
      if (count_q == compare_q) begin
        timer_ip_d = 1'b1;
      end else begin
        timer_ip_d = timer_ip_q;
      end
    end else begin
      count_d = count_q;
    end
`endif
    if (cp0_ena) begin
      if (take_s) begin
        // Pushing a frame drops the oldest one once the stack is full.
        status_d = status_q << FRAME_W;
        cause_d[EXCCODE_HI:EXCCODE_LO] = entry_code(exc_req, exc_code);
        epc_d = pc_in;
        if (level_q == LVL_MAX) begin
          nest_ovf_d = 1'b1;
        end else begin
          level_d = level_q + LVL_W'(1);
        end
      end else if (eret) begin
        status_d = status_q >> FRAME_W;
        if (level_q != '0) begin
          level_d = level_q - LVL_W'(1);
        end else begin
          level_d = level_q;
        end
      end else if (mtc0) begin
        case (addr)
          CP0_REG_STATUS: status_d = data_in;
          CP0_REG_CAUSE: begin
            cause_d = data_in;
            cause_d[IP_HI:IP_LO] = 8'h00;
          end
          CP0_REG_EPC:    epc_d = data_in;
`ifdef CP0_TIMER_EN
          CP0_REG_COUNT:  count_d = data_in;
          CP0_REG_COMPARE: begin
            compare_d  = data_in;
            timer_ip_d = 1'b0;
          end
`endif
          default: ;
        endcase
      end else begin
        status_d = status_q;
      end
    end else begin
      status_d = status_q;
    end
  end

  // Architectural state, updated on the falling edge.
  always_ff @(negedge cp0_clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      status_q   <= STATUS_RST;
      cause_q    <= '0;
      epc_q      <= '0;
      level_q    <= '0;
      nest_ovf_q <= 1'b0;
`ifdef CP0_TIMER_EN
      count_q    <= '0;
      compare_q  <= '0;
      timer_ip_q <= 1'b0;
`endif
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      level_q    <= level_d;
      nest_ovf_q <= nest_ovf_d;
`ifdef CP0_TIMER_EN
      count_q    <= count_d;
      compare_q  <= compare_d;
      timer_ip_q <= timer_ip_d;
`endif
    end
  end

  assign cp0_out    = (cp0_ena & mfc0) ? rd_data_s : '0;
  assign epc_out    = (cp0_ena & eret) ? epc_q : '0;
  assign exc_taken  = take_s;
  assign exc_vector = take_s ? EXC_VECTOR : '0;
  assign nest_ovf   = nest_ovf_q;

endmodule
